dekatron_counter: RTL and testbench

Multi-digit one-hot ring counter generalising the single-digit dekatron cell to a parametrised chain of DIGITS rings of RADIX positions each. It increments, decrements or loads on a request/ready handshake, and propagates carry/borrow one digit per clock to mimic tube-to-tube transfer timing. It serves as the IP/AP/data counters of the dekatron CPU core, replacing hand-chained single-digit cells.

---
 rtl/dekatron_pkg.sv | 25 ++
 rtl/dekatron_ring.sv | 53 +++++
 rtl/dekatron_counter.sv | 176 +++++++++++++++++
 tb/tb_dekatron_counter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dekatron_pkg.sv
// Shared types and constants for the dekatron ring counter.
// The optional one-hot load checker is enabled by DEKATRON_ONEHOT_CHECK_EN.
package dekatron_pkg;

    localparam int DEFAULT_DIGITS = 3;
    localparam int DEFAULT_RADIX  = 10;
    // Widest ring the position-0 helper can describe.
    localparam int MAX_RADIX      = 64;

    typedef enum logic {
        IDLE   = 1'b0,
        RIPPLE = 1'b1
    } state_t;

    // One-hot pattern for position 0. Callers slice the low RADIX bits.
    function automatic logic [MAX_RADIX-1:0] pos0_onehot(input int radix);
        logic [MAX_RADIX-1:0] r;
        r = '0;
        if (radix > 0) begin
            r[0] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dekatron_ring.sv
// One dekatron digit: a RADIX-position one-hot ring that rotates one step
// per enabled cycle or loads a new pattern. The wrap flag is combinational
// and tells the controller whether a rotation in the requested direction
// would pass through position 0.
module dekatron_ring
    import dekatron_pkg::*;
#(
    parameter int RADIX = DEFAULT_RADIX
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             rotate,
    input  logic             dec,
    input  logic             load,
    input  logic [RADIX-1:0] load_value,
    output logic [RADIX-1:0] value,
    output logic             wrap
);

    localparam logic [MAX_RADIX-1:0] POS0_FULL = pos0_onehot(RADIX);
    localparam logic [RADIX-1:0]     POS0      = POS0_FULL[RADIX-1:0];

    logic [RADIX-1:0] value_d;

    // Next ring value: load wins over rotation; the pattern shape is kept.
    always_comb begin
        value_d = value;
        if (load) begin
            value_d = load_value;
        end else if (rotate) begin
            if (dec) begin
                value_d = {value[0], value[RADIX-1:1]};
            end else begin
                value_d = {value[RADIX-2:0], value[RADIX-1]};
            end
        end
    end

    // A decrement wraps out of position 0, an increment out of RADIX-1.
    always_comb begin
        wrap = dec ? value[0] : value[RADIX-1];
    end

    // Ring register, cleared to position 0.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            value <= POS0;
        end else begin
            value <= value_d;
        end
    end

endmodule

// File: rtl/dekatron_counter.sv
// Multi-digit dekatron counter. Digit 0 steps on an accepted request; any
// carry or borrow then moves up one digit per clock while Ready is low.
// Defining DEKATRON_ONEHOT_CHECK_EN adds the Err output and replaces
// malformed load digits by position 0.
//
// state  | meaning
// IDLE   | Ready high, request accepted on the next edge
// RIPPLE | rotating digit idx in the latched direction
module dekatron_counter
    import dekatron_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int RADIX  = DEFAULT_RADIX
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Request,
    input  logic                    Dec,
    input  logic                    Set,
    input  logic [DIGITS*RADIX-1:0] In,
    output logic [DIGITS*RADIX-1:0] Out,
    output logic                    Ready,
    output logic                    Carry,
`ifdef DEKATRON_ONEHOT_CHECK_EN
    output logic                    Zero,
    output logic                    Err
`else
    output logic                    Zero
`endif
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [MAX_RADIX-1:0] POS0_FULL = pos0_onehot(RADIX);
    localparam logic [RADIX-1:0]     POS0      = POS0_FULL[RADIX-1:0];

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    dir_q, dir_d;
    logic                    rot_dir;
    logic                    load_en;
    logic                    carry_d;
    logic [DIGITS-1:0]       rot_en;
    logic [DIGITS-1:0]       wrap;
    logic [DIGITS*RADIX-1:0] load_value;

`ifdef DEKATRON_ONEHOT_CHECK_EN
    logic [DIGITS-1:0] load_bad;
    logic              err_q;

    function automatic logic is_onehot(input logic [RADIX-1:0] v);
        int n;
        n = 0;
        for (int b = 0; b < RADIX; b++) begin
            n = n + int'(v[b]);
        end
        return (n == 1);
    endfunction

    // Malformed load digits are forced to position 0 and flagged.
    always_comb begin
        load_value = In;
        load_bad   = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (!is_onehot(In[d*RADIX +: RADIX])) begin
                load_bad[d]                  = 1'b1;
                load_value[d*RADIX +: RADIX] = POS0;
            end
        end
    end

    // Err follows the most recent load and holds between loads.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_q <= 1'b0;
        end else if (load_en) begin
            err_q <= |load_bad;
        end
    end

    assign Err = err_q;
`else
    assign load_value = In;
`endif

    // Next state, per-digit rotate enables and the carry pulse request.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        rot_dir = dir_q;
        rot_en  = '0;
        load_en = 1'b0;
        carry_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (Request) begin
                    if (Set) begin
                        load_en = 1'b1;
                    end else begin
                        rot_dir   = Dec;
                        rot_en[0] = 1'b1;
                        if (wrap[0]) begin
                            if (DIGITS > 1) begin
                                dir_d   = Dec;
                                idx_d   = IDX_W'(1);
                                state_d = RIPPLE;
                            end else begin
                                carry_d = 1'b1;
                            end
                        end
                    end
                end
            end
            RIPPLE: begin
                rot_en[idx_q] = 1'b1;
                if (wrap[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        carry_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers; Ready and Carry are registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            Ready   <= 1'b1;
            Carry   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            Ready   <= (state_d == IDLE);
            Carry   <= carry_d;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        dekatron_ring #(
            .RADIX(RADIX)
        ) u_ring (
            .Clk       (Clk),
            .Rst_n     (Rst_n),
            .rotate    (rot_en[d]),
            .dec       (rot_dir),
            .load      (load_en),
            .load_value(load_value[d*RADIX +: RADIX]),
            .value     (Out[d*RADIX +: RADIX]),
            .wrap      (wrap[d])
        );
    end

    // Zero compares every digit's raw pattern against position 0.
    always_comb begin
        Zero = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (Out[d*RADIX +: RADIX] != POS0) begin
                Zero = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dekatron_counter.sv
// Directed bench for dekatron_counter with an integer-valued reference
// model and a per-cycle compare process.
module tb_dekatron_counter;

    localparam int DIGITS = 3;
    localparam int RADIX  = 10;
    localparam int W      = DIGITS * RADIX;
    localparam int MODV   = 1000;

    logic         Clk     = 1'b0;
    logic         Rst_n   = 1'b0;
    logic         Request = 1'b0;
    logic         Dec     = 1'b0;
    logic         Set     = 1'b0;
    logic [W-1:0] In      = '0;
    logic [W-1:0] Out;
    logic         Ready;
    logic         Carry;
    logic         Zero;
`ifdef DEKATRON_ONEHOT_CHECK_EN
    logic         Err;
`endif

    dekatron_counter #(.DIGITS(DIGITS), .RADIX(RADIX)) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Request(Request),
        .Dec    (Dec),
        .Set    (Set),
        .In     (In),
        .Out    (Out),
        .Ready  (Ready),
        .Carry  (Carry),
`ifdef DEKATRON_ONEHOT_CHECK_EN
        .Zero   (Zero),
        .Err    (Err)
`else
        .Zero   (Zero)
`endif
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int ready_low_cnt = 0;
    int carry_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] enc(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*RADIX + (t % RADIX)] = 1'b1;
            t = t / RADIX;
        end
        return r;
    endfunction

    function automatic int digit_pos(input logic [RADIX-1:0] v);
        int n;
        int p;
        n = 0;
        p = -1;
        for (int b = 0; b < RADIX; b++) begin
            if (v[b]) begin
                n++;
                p = b;
            end
        end
        return (n == 1) ? p : -1;
    endfunction

    // Reference model: the counter value as an integer, plus how many
    // cycles the counter stays busy after a step and whether that step
    // overflowed the whole chain.
    int m_val   = 0;
    int m_busy  = 0;
    bit m_full  = 1'b0;
    bit m_carry = 1'b0;
    bit m_err   = 1'b0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_val   = 0;
            m_busy  = 0;
            m_full  = 1'b0;
            m_carry = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_carry = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0 && m_full) m_carry = 1'b1;
            end else if (Request) begin
                if (Set) begin
                    int p;
                    int pos;
                    bit bad;
                    m_val = 0;
                    p = 1;
                    bad = 1'b0;
                    for (int d = 0; d < DIGITS; d++) begin
                        pos = digit_pos(In[d*RADIX +: RADIX]);
                        if (pos < 0) begin
                            bad = 1'b1;
                            pos = 0;
                        end
                        m_val += pos * p;
                        p *= RADIX;
                    end
                    m_err = bad;
                end else begin
                    int trail;
                    int t;
                    trail = 0;
                    t = m_val;
                    for (int d = 0; d < DIGITS; d++) begin
                        if ((t % RADIX) != (Dec ? 0 : RADIX - 1)) break;
                        trail++;
                        t = t / RADIX;
                    end
                    m_val = Dec ? (m_val + MODV - 1) % MODV : (m_val + 1) % MODV;
                    m_full = (trail >= DIGITS);
                    if (trail >= DIGITS) begin
                        if (DIGITS == 1) m_carry = 1'b1;
                        else m_busy = DIGITS - 1;
                    end else begin
                        m_busy = trail;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge Clk) begin
        if (Rst_n) begin
            check("ready", Ready, (m_busy == 0));
            if (m_busy == 0) begin
                check("out", Out, enc(m_val));
                check("zero", Zero, (m_val == 0));
            end
            check("carry", Carry, m_carry);
`ifdef DEKATRON_ONEHOT_CHECK_EN
            check("err", Err, m_err);
`endif
            if (!Ready) ready_low_cnt++;
            if (Carry) carry_cnt++;
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!Ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_timeout", Ready, 1'b1);
    endtask

    task automatic op(input bit s, input bit d, input logic [W-1:0] v);
        Request = 1'b1;
        Set = s;
        Dec = d;
        In = v;
        tick();
        Request = 1'b0;
        Set = 1'b0;
        Dec = 1'b0;
        wait_ready();
    endtask

    task automatic clear_counts();
        ready_low_cnt = 0;
        carry_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] lit;
        logic [RADIX-1:0] bad_digit;

        tick();
        tick();
        lit = {3{10'b0000000001}};
        check("rst_out", Out, lit);
        check("rst_ready", Ready, 1'b1);
        check("rst_carry", Carry, 1'b0);
        check("rst_zero", Zero, 1'b1);
        Rst_n = 1'b1;
        tick();

        // 12 increments from zero: one single-digit ripple at 009 -> 010
        clear_counts();
        repeat (12) op(1'b0, 1'b0, '0);
        lit = {10'b0000000001, 10'b0000000010, 10'b0000000100};
        check("inc12_out", Out, lit);
        check("inc12_ready_low", ready_low_cnt, 1);
        check("inc12_carry", carry_cnt, 0);

        // back-to-back increments, no ripple
        Request = 1'b1;
        repeat (3) tick();
        Request = 1'b0;
        tick();
        lit = {10'b0000000001, 10'b0000000010, 10'b0000100000};
        check("b2b_out", Out, lit);
        check("b2b_ready_low", ready_low_cnt, 1);

        // 099 + 1 with visible intermediate values
        op(1'b1, 1'b0, enc(99));
        clear_counts();
        Request = 1'b1;
        tick();
        Request = 1'b0;
        check("rip_mid1", Out, enc(90));
        check("rip_busy", Ready, 1'b0);
        tick();
        check("rip_mid2", Out, enc(0));
        tick();
        check("rip_final", Out, enc(100));
        check("rip_ready", Ready, 1'b1);
        check("rip_ready_low", ready_low_cnt, 2);
        check("rip_carry", carry_cnt, 0);

        // 999 + 1 full overflow, then 000 - 1 full underflow
        op(1'b1, 1'b0, enc(999));
        clear_counts();
        op(1'b0, 1'b0, '0);
        check("ovf_out", Out, {3{10'b0000000001}});
        check("ovf_zero", Zero, 1'b1);
        check("ovf_carry_now", Carry, 1'b1);
        check("ovf_ready_low", ready_low_cnt, 2);
        tick();
        check("ovf_carry_cnt", carry_cnt, 1);
        clear_counts();
        op(1'b0, 1'b1, '0);
        check("udf_out", Out, {3{10'b1000000000}});
        tick();
        check("udf_carry_cnt", carry_cnt, 1);

        // load request held during ripple is ignored until Ready returns
        op(1'b1, 1'b0, enc(9));
        Request = 1'b1;
        tick();
        Set = 1'b1;
        In = enc(555);
        tick();
        check("hold_mid", Out, enc(10));
        tick();
        Request = 1'b0;
        Set = 1'b0;
        check("hold_load", Out, enc(555));
        tick();

        // borrow across two digits: 100 - 1
        op(1'b1, 1'b0, enc(100));
        op(1'b0, 1'b1, '0);
        check("dec_borrow", Out, enc(99));

        // reset in the middle of a ripple
        op(1'b1, 1'b0, enc(99));
        Request = 1'b1;
        tick();
        Request = 1'b0;
        Rst_n = 1'b0;
        #1;
        check("arst_out", Out, {3{10'b0000000001}});
        check("arst_ready", Ready, 1'b1);
        check("arst_carry", Carry, 1'b0);
        tick();
        tick();
        Rst_n = 1'b1;
        tick();
        check("arst_hold", Out, {3{10'b0000000001}});

`ifdef DEKATRON_ONEHOT_CHECK_EN
        lit = enc(123);
        bad_digit = 10'b0000000011;
        lit[RADIX +: RADIX] = bad_digit;
        op(1'b1, 1'b0, lit);
        check("err_out", Out, enc(103));
        check("err_set", Err, 1'b1);
        op(1'b1, 1'b0, enc(42));
        check("err_clear", Err, 1'b0);
`else
        bad_digit = '0;
        check("noerr_bits", bad_digit, '0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
